// File: rtl/m_seaquence_checker.sv
// m_seaquence_checker: combinational run detector for a ROWS x COLS occupancy
// bitboard. Cell (r, c) is bit r*COLS+c. o_detected is high when SEAQUENCE
// consecutive set cells exist horizontally, vertically or on either diagonal.
module m_seaquence_checker #(
  parameter int ROWS      = 6,
  parameter int COLS      = 7,
  parameter int SEAQUENCE = 4
) (
  input  logic [ROWS*COLS-1:0] i_field,
  output logic                 o_detected
);

  localparam int N = ROWS * COLS;

  // Mask of the run starting at (r, c) in direction d:
  // 0 = right, 1 = down, 2 = down-right, 3 = down-left. Zero if it leaves the board.
  function automatic logic [N-1:0] f_mask(input int r, input int c, input int d);
    logic [N-1:0] m;
    logic         ok;
    int           rr;
    int           cc;
    m  = '0;
    ok = 1'b1;
    for (int k = 0; k < SEAQUENCE; k++) begin
      rr = (d == 0) ? r : r + k;
      cc = (d == 1) ? c : ((d == 3) ? c - k : c + k);
      if (rr >= ROWS || cc < 0 || cc >= COLS) begin
        ok = 1'b0;
      end else begin
        m = m | (N'(1) << (rr * COLS + cc));
      end
    end
    return ok ? m : '0;
  endfunction

  logic [4*N-1:0] w_runs;

  for (genvar gd = 0; gd < 4; gd++) begin : g_dir
    for (genvar gp = 0; gp < N; gp++) begin : g_pos
      localparam logic [N-1:0] MASK = f_mask(gp / COLS, gp % COLS, gd);
      assign w_runs[gd*N+gp] = (MASK != '0) && ((i_field & MASK) == MASK);
    end
  end

  assign o_detected = |w_runs;

endmodule

// File: rtl/m_drop_game_ctrl.sv
// m_drop_game_ctrl: turn sequencer for the two-player drop game. Owns both
// players' bitboards, applies gravity to each column drop, checks the mover's
// board with one shared m_seaquence_checker and reports PLACED/REJECT/WIN/DRAW.
// Geometry macros normally come from config.vh; the defaults below apply only
// when that file has not been read ahead of this one.
`ifndef COL_COUNT
`define COL_COUNT 7
`endif
`ifndef FIELD_SIZE
`define FIELD_SIZE 42
`endif

module m_drop_game_ctrl #(
  parameter int SEAQUENCE = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_move_valid,
  input  logic [$clog2(`COL_COUNT)-1:0] i_move_col,
  output logic                          o_move_ready,
  input  logic                          i_restart,
  output logic                          o_resp_valid,
  output logic [1:0]                    o_resp_status,
  output logic                          o_turn,
  output logic                          o_winner,
  output logic                          o_over,
  output logic [`FIELD_SIZE-1:0]        o_field_p0,
  output logic [`FIELD_SIZE-1:0]        o_field_p1
);

  localparam int COLS = `COL_COUNT;
  localparam int N    = `FIELD_SIZE;
  localparam int ROWS = N / COLS;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int MW   = $clog2(N + 1);

  localparam logic [1:0] ST_PLACED = 2'd0;
  localparam logic [1:0] ST_REJECT = 2'd1;
  localparam logic [1:0] ST_WIN    = 2'd2;
  localparam logic [1:0] ST_DRAW   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PLACE,
    S_CHECK,
    S_RESOLVE,
    S_OVER
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic            r_mover;
  logic [RW-1:0]   r_row;
  logic            r_reject;
  logic            r_hit;
  logic [MW-1:0]   r_cnt;
  logic [N-1:0]    r_field_p0;
  logic [N-1:0]    r_field_p1;
  logic            r_turn;
  logic            r_over;
  logic            r_winner;

  logic [N-1:0]    w_occ;
  logic [IW-1:0]   w_idx;
  logic            w_cell;
  logic [N-1:0]    w_bit;
  logic [N-1:0]    w_chk_field;
  logic            w_detected;
  logic            w_col_ok;
  logic            w_clear;
  logic [1:0]      w_status;

  // Gravity scan looks at the union of both boards; the row pointer walks up
  // from the bottom, so the first empty cell found is the landing cell.
  assign w_occ       = r_field_p0 | r_field_p1;
  assign w_idx       = IW'(int'(r_row) * COLS + int'(r_col));
  assign w_cell      = w_occ[w_idx];
  assign w_bit       = N'(1) << w_idx;
  assign w_col_ok    = (int'(i_move_col) < COLS);
  assign w_chk_field = r_mover ? r_field_p1 : r_field_p0;
  assign w_clear     = i_restart && ((r_state == S_IDLE) || (r_state == S_OVER));

  m_seaquence_checker #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SEAQUENCE (SEAQUENCE)
  ) u_checker (
    .i_field    (w_chk_field),
    .o_detected (w_detected)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake outputs and response status (REJECT > WIN > DRAW > PLACED).
  always_comb begin
    w_state_nxt   = r_state;
    w_status      = ST_PLACED;
    o_move_ready  = 1'b0;
    o_resp_valid  = 1'b0;
    o_resp_status = ST_PLACED;
    if (r_reject) begin
      w_status = ST_REJECT;
    end else if (r_hit) begin
      w_status = ST_WIN;
    end else if (r_cnt == MW'(N)) begin
      w_status = ST_DRAW;
    end
    case (r_state)
      S_IDLE: begin
        o_move_ready = 1'b1;
        if (!i_restart && i_move_valid) begin
          w_state_nxt = w_col_ok ? S_SCAN : S_RESOLVE;
        end
      end
      S_SCAN: begin
        if (!w_cell) begin
          w_state_nxt = S_PLACE;
        end else if (r_row == '0) begin
          w_state_nxt = S_RESOLVE;
        end
      end
      S_PLACE: w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_RESOLVE;
      S_RESOLVE: begin
        o_resp_valid  = 1'b1;
        o_resp_status = w_status;
        w_state_nxt   = ((w_status == ST_WIN) || (w_status == ST_DRAW)) ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        if (i_restart) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Move bookkeeping: latch request, scan, place piece, capture hit, resolve turn/game end.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_col      <= '0;
      r_mover    <= 1'b0;
      r_row      <= '0;
      r_reject   <= 1'b0;
      r_hit      <= 1'b0;
      r_cnt      <= '0;
      r_field_p0 <= '0;
      r_field_p1 <= '0;
      r_turn     <= 1'b0;
      r_over     <= 1'b0;
      r_winner   <= 1'b0;
    end else if (w_clear) begin
      r_reject   <= 1'b0;
      r_hit      <= 1'b0;
      r_cnt      <= '0;
      r_field_p0 <= '0;
      r_field_p1 <= '0;
      r_turn     <= 1'b0;
      r_over     <= 1'b0;
      r_winner   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_move_valid) begin
            r_col    <= i_move_col;
            r_mover  <= r_turn;
            r_row    <= RW'(ROWS - 1);
            r_reject <= !w_col_ok;
            r_hit    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_cell) begin
            if (r_row == '0) begin
              r_reject <= 1'b1;
            end else begin
              r_row <= r_row - RW'(1);
            end
          end
        end
        S_PLACE: begin
          if (r_mover) begin
            r_field_p1 <= r_field_p1 | w_bit;
          end else begin
            r_field_p0 <= r_field_p0 | w_bit;
          end
          r_cnt <= r_cnt + MW'(1);
        end
        S_CHECK: r_hit <= w_detected;
        S_RESOLVE: begin
          case (w_status)
            ST_PLACED: r_turn <= ~r_turn;
            ST_WIN: begin
              r_over   <= 1'b1;
              r_winner <= r_mover;
            end
            ST_DRAW: r_over <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_turn     = r_turn;
  assign o_over     = r_over;
  assign o_winner   = r_winner;
  assign o_field_p0 = r_field_p0;
  assign o_field_p1 = r_field_p1;

endmodule
